// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 matrix keypad scanner.
// FSM state encoding, matrix geometry and column-pattern decoding.
package keypad_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_e;

    // True when exactly one column is pulled low; anything else reads as "no key".
    function automatic logic col_is_single(input logic [COLS-1:0] col_n);
        int unsigned lows;
        lows = 0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (!col_n[i]) lows++;
        end
        return (lows == 1);
    endfunction

    // Index of the low column in an active-low one-hot pattern.
    function automatic logic [1:0] col_to_idx(input logic [COLS-1:0] col_n);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (!col_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad matrix lines plus the decoded key output handshake.
// master = scanner side, slave = keypad/consumer side.
interface keypad_if;
    import keypad_pkg::*;

    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_out;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;

    modport master (
        input  col_in,
        output row_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_slot_timer.sv
// keypad_slot_timer: free-running row-slot counter; slot_end_o marks the
// last cycle of each SCAN_DIV-cycle slot.
module keypad_slot_timer #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end_o
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign slot_end_o = (cnt_q == CW'(SCAN_DIV - 1));

    // Next count: wrap to zero on the last cycle of the slot.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (slot_end_o) cnt_d = '0;
    end

    // Slot counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives one keypad row low per slot, samples the synchronized
// columns at slot end, debounces, and reports one key code with a 1-cycle strobe.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DLY   = 64,
    parameter int unsigned REPEAT_PER   = 16
`endif
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned RW = $clog2(ROWS);

    logic            slot_end;
    logic [COLS-1:0] sync1_q, sync2_q;
    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] pat_q, pat_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;
    logic            key_ok;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RPW  = $clog2(RMAX + 1);

    logic [RPW-1:0] rep_q, rep_d;
    logic           rep_first_q, rep_first_d;
`endif

    keypad_slot_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .slot_end_o (slot_end)
    );

    assign key_ok = col_is_single(sync2_q);

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ROW_IDLE;
            sync2_q <= ROW_IDLE;
        end else begin
            sync1_q <= kp.col_in;
            sync2_q <= sync1_q;
        end
    end

    // Next-state and output decode; only slot_end samples move the FSM.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pat_d   = pat_q;
        deb_d   = deb_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        if (slot_end) begin
            unique case (state_q)
                SCAN: begin
                    if (key_ok) begin
                        pat_d   = sync2_q;
                        deb_d   = DW'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (sync2_q == pat_q) begin
                        deb_d = deb_q + DW'(1);
                        if ((deb_q + DW'(1)) == DW'(DEBOUNCE_CNT)) begin
                            state_d = PRESSED;
                            code_d  = {row_q, col_to_idx(pat_q)};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            deb_d   = '0;
                        end
                    end else begin
                        state_d = SCAN;
                        row_d   = row_q + RW'(1);
                        deb_d   = '0;
                    end
                end
                PRESSED: begin
                    // Any valid pattern, even a different key, restarts the release count.
                    if (key_ok) begin
                        deb_d = '0;
                    end else begin
                        deb_d = deb_q + DW'(1);
                    end
                    if (!key_ok && ((deb_q + DW'(1)) == DW'(DEBOUNCE_CNT))) begin
                        state_d = SCAN;
                        row_d   = row_q + RW'(1);
                        held_d  = 1'b0;
                        deb_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_d       = '0;
                        rep_first_d = 1'b0;
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        // First repeat after REPEAT_DLY slots, then every REPEAT_PER slots.
                        rep_d = rep_q + RPW'(1);
                        if ((!rep_first_q && ((rep_q + RPW'(1)) == RPW'(REPEAT_DLY))) ||
                            ( rep_first_q && ((rep_q + RPW'(1)) == RPW'(REPEAT_PER)))) begin
                            valid_d     = 1'b1;
                            rep_d       = '0;
                            rep_first_d = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            row_q   <= '0;
            pat_q   <= ROW_IDLE;
            deb_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
            deb_q   <= deb_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat slot counter, idle outside PRESSED.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q       <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign kp.row_out   = ROW_IDLE & ~(4'b0001 << row_q);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_CNT=3 against a behavioural 4x4 switch matrix.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] keys;
    int          n_cmp;
    int          n_bad;
    int          pulses;
    int          first_at;

    logic [3:0] rowpat [4];

    keypad_if kp ();

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a pressed key at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        logic [3:0] c;
        c = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (!kp.row_out[r] && keys[r*4+cc]) c[cc] = 1'b0;
            end
        end
        kp.col_in = c;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ends on the negedge where rst drops (reference cycle N0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance n negedges, counting key_valid strobes; first_at is the 1-based cycle.
    task automatic count_pulses(input int n, output int np, output int first);
        np    = 0;
        first = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (kp.key_valid === 1'b1) begin
                np++;
                if (first < 0) first = k;
            end
        end
    endtask

    initial begin
        int bp;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        keys  = '0;
        rowpat[0] = 4'b1110;
        rowpat[1] = 4'b1101;
        rowpat[2] = 4'b1011;
        rowpat[3] = 4'b0111;

        // Reset values and idle row rotation.
        do_reset();
        check("rst_row",   kp.row_out,   4'b1110);
        check("rst_valid", kp.key_valid, 1'b0);
        check("rst_held",  kp.key_held,  1'b0);
        check("rst_code",  kp.key_code,  4'h0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if ((k % 4) == 0) check("scan_row", kp.row_out, rowpat[(k/4)%4]);
        end

        // Clean press of row2/col1: one strobe at N20, code 1001, row frozen.
        do_reset();
        keys = 16'h0200;
        count_pulses(40, pulses, first_at);
        check("press_pulses",  pulses,      1);
        check("press_latency", first_at,    20);
        check("press_code",    kp.key_code, 4'b1001);
        check("press_held",    kp.key_held, 1'b1);
        check("press_row",     kp.row_out,  4'b1011);

        // Release: held drops after 3 no-key slots, scan moves to row 3.
        keys = '0;
        count_pulses(11, pulses, first_at);
        check("rel_held_still", kp.key_held, 1'b1);
        check("rel_no_pulse",   pulses,      0);
        @(negedge clk);
        check("rel_held_fall", kp.key_held, 1'b0);
        check("rel_row_next",  kp.row_out,  4'b0111);
        check("rel_code_hold", kp.key_code, 4'b1001);

        // Reset in the middle of a held press, then re-detection from scratch.
        do_reset();
        keys = 16'h0200;
        count_pulses(30, pulses, first_at);
        check("mid_pre_held", kp.key_held, 1'b1);
        do_reset();
        check("mid_rst_held", kp.key_held, 1'b0);
        check("mid_rst_code", kp.key_code, 4'h0);
        check("mid_rst_row",  kp.row_out,  4'b1110);
        count_pulses(40, pulses, first_at);
        check("mid_re_pulses",  pulses,   1);
        check("mid_re_latency", first_at, 20);

        // Swap to another key in the frozen row while held: no strobe until release.
        keys = 16'h0800;
        count_pulses(24, pulses, first_at);
        check("swap_pulses", pulses,      0);
        check("swap_held",   kp.key_held, 1'b1);
        check("swap_code",   kp.key_code, 4'b1001);
        check("swap_row",    kp.row_out,  4'b1011);
        keys = '0;
        count_pulses(11, pulses, first_at);
        check("swap_rel_still", kp.key_held, 1'b1);
        @(negedge clk);
        check("swap_rel_fall", kp.key_held, 1'b0);
        check("swap_rel_row",  kp.row_out,  4'b0111);

        // Bounce: key toggles every slot; debounce aborts and scan resumes.
        do_reset();
        bp = 0;
        for (int k = 0; k < 64; k++) begin
            keys = (k >= 8 && k < 32 && ((k / 4) % 2) == 0) ? 16'h0200 : 16'h0000;
            if (k == 12) check("bounce_frozen", kp.row_out, 4'b1011);
            if (k == 16) check("bounce_resume", kp.row_out, 4'b0111);
            if (kp.key_valid === 1'b1) bp++;
            @(negedge clk);
        end
        check("bounce_pulses", bp,          0);
        check("bounce_held",   kp.key_held, 1'b0);

        // Two keys in row 0 (col_in=1100): rejected, scan never freezes.
        do_reset();
        keys = 16'h0003;
        count_pulses(4, pulses, first_at);
        check("multi_row_n4", kp.row_out, 4'b1101);
        bp = pulses;
        count_pulses(36, pulses, first_at);
        check("multi_pulses", bp + pulses, 0);
        check("multi_held",   kp.key_held, 1'b0);
        check("multi_row",    kp.row_out,  4'b1011);
        keys = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
